// File: rtl/config_field_selector.sv
// Field-select front end: synchronises and debounces four push-buttons and drives en_count/enUP/enDOWN.
// Optional build macro FIELD_WRAP_EN makes left/right wrap at the field range ends instead of saturating.
module config_field_selector #(
   parameter int DEB_CYCLES = 1_000_000,
   parameter int NUM_FIELDS = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       config_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [3:0] en_count,
   output logic       enUP,
   output logic       enDOWN
);

   localparam int               CNT_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [3:0]       FIELD_MIN = 4'd1;
   localparam logic [3:0]       FIELD_MAX = 4'(NUM_FIELDS);

   // Button bit positions inside the packed vectors
   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_RIGHT = 3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SELECT = 1'b1
   } state_t;

   logic [3:0]       raw_s;
   logic [3:0]       sync1_q;
   logic [3:0]       sync2_q;
   logic [3:0]       db_q;
   logic [3:0]       db_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [1:0]       lr_prev_q;
   logic             l_evt_s;
   logic             r_evt_s;

   state_t           state_q;
   state_t           state_d;
   logic [3:0]       en_count_q;
   logic [3:0]       en_count_d;
   logic             en_up_q;
   logic             en_up_d;
   logic             en_down_q;
   logic             en_down_d;

   function automatic logic [3:0] step_right(input logic [3:0] cur);
      logic [3:0] nxt;
      if (cur >= FIELD_MAX) begin
`ifdef FIELD_WRAP_EN
         nxt = FIELD_MIN;
`else
         nxt = FIELD_MAX;
`endif
      end else begin
         nxt = cur + 4'd1;
      end
      return nxt;
   endfunction

   function automatic logic [3:0] step_left(input logic [3:0] cur);
      logic [3:0] nxt;
      if (cur <= FIELD_MIN) begin
`ifdef FIELD_WRAP_EN
         nxt = FIELD_MAX;
`else
         nxt = FIELD_MIN;
`endif
      end else begin
         nxt = cur - 4'd1;
      end
      return nxt;
   endfunction

   assign raw_s = {btn_right, btn_left, btn_down, btn_up};

   // Debounce next-state: a differing sync value must persist DEB_CYCLES clocks before it is accepted
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = CNT_ZERO;
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = CNT_ZERO;
         end else if (cnt_q[i] == DEB_LAST) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = CNT_ZERO;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // Synchroniser, debouncer and left/right history registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 4'b0000;
         sync2_q   <= 4'b0000;
         db_q      <= 4'b0000;
         lr_prev_q <= 2'b00;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
      end else begin
         sync1_q   <= raw_s;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         lr_prev_q <= {db_q[B_RIGHT], db_q[B_LEFT]};
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // A press already debounced before SELECT leaves no edge here, so it needs a release and re-press
   assign l_evt_s = db_q[B_LEFT]  & ~lr_prev_q[0];
   assign r_evt_s = db_q[B_RIGHT] & ~lr_prev_q[1];

   // Field-select FSM next state and output values
   always_comb begin
      state_d    = state_q;
      en_count_d = en_count_q;
      en_up_d    = 1'b0;
      en_down_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (config_mode) begin
               state_d    = ST_SELECT;
               en_count_d = FIELD_MIN;
            end else begin
               state_d    = ST_IDLE;
               en_count_d = 4'd0;
            end
         end
         ST_SELECT: begin
            if (!config_mode) begin
               state_d    = ST_IDLE;
               en_count_d = 4'd0;
            end else begin
               state_d = ST_SELECT;
               if (r_evt_s && !l_evt_s) begin
                  en_count_d = step_right(en_count_q);
               end else if (l_evt_s && !r_evt_s) begin
                  en_count_d = step_left(en_count_q);
               end else begin
                  en_count_d = en_count_q;
               end
               // Up/down are suppressed for the cycle a new field code is presented
               if (en_count_d == en_count_q) begin
                  en_up_d   = db_q[B_UP]   & ~db_q[B_DOWN];
                  en_down_d = db_q[B_DOWN] & ~db_q[B_UP];
               end else begin
                  en_up_d   = 1'b0;
                  en_down_d = 1'b0;
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            en_count_d = 4'd0;
         end
      endcase
   end

   // Field-select FSM state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         en_count_q <= 4'd0;
         en_up_q    <= 1'b0;
         en_down_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_count_q <= en_count_d;
         en_up_q    <= en_up_d;
         en_down_q  <= en_down_d;
      end
   end

   assign en_count = en_count_q;
   assign enUP     = en_up_q;
   assign enDOWN   = en_down_q;

endmodule

// File: tb/tb_config_field_selector.sv
// Directed self-checking bench for config_field_selector (DEB_CYCLES=4, NUM_FIELDS=9); honours FIELD_WRAP_EN.
module tb_config_field_selector;

   logic       clk;
   logic       reset;
   logic       config_mode;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic [3:0] en_count;
   logic       enUP;
   logic       enDOWN;

   int n_checks;
   int n_fail;

`ifdef FIELD_WRAP_EN
   localparam logic [3:0] EXP_RIGHT_AT_MAX = 4'd1;
   localparam logic [3:0] EXP_LEFT_AT_MIN  = 4'd9;
`else
   localparam logic [3:0] EXP_RIGHT_AT_MAX = 4'd9;
   localparam logic [3:0] EXP_LEFT_AT_MIN  = 4'd1;
`endif

   config_field_selector #(
      .DEB_CYCLES(4),
      .NUM_FIELDS(9)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .config_mode(config_mode),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .en_count   (en_count),
      .enUP       (enUP),
      .enDOWN     (enDOWN)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press right (r) and/or left (l) together for hold clocks, then release and let it settle
   task automatic press_lr(input logic r, input logic l, input int hold);
      btn_right = r;
      btn_left  = l;
      tick(hold);
      btn_right = 1'b0;
      btn_left  = 1'b0;
      tick(10);
   endtask

   task automatic test_reset;
      reset = 1'b0; config_mode = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      tick(3);
      n_checks++;
      if (en_count !== 4'd0 || enUP !== 1'b0 || enDOWN !== 1'b0) begin
         n_fail++; $display("FAIL reset_init: en_count=%0d enUP=%b enDOWN=%b, required 0/0/0", en_count, enUP, enDOWN);
      end
      reset = 1'b1;
      config_mode = 1'b1;
      btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
      tick(20);
      n_checks++;
      if (en_count !== 4'd1) begin
         n_fail++; $display("FAIL run_before_reset: en_count=%0d required 1", en_count);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (en_count !== 4'd0 || enUP !== 1'b0 || enDOWN !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: en_count=%0d enUP=%b enDOWN=%b, required 0/0/0", en_count, enUP, enDOWN);
      end
      config_mode = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      #2 reset = 1'b1;
      tick(10);
      n_checks++;
      if (en_count !== 4'd0 || enUP !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: en_count=%0d enUP=%b, required 0/0", en_count, enUP);
      end
   endtask

   task automatic test_midpress_reset;
      config_mode = 1'b1;
      tick(1);
      btn_up = 1'b1;
      tick(7);
      n_checks++;
      if (enUP !== 1'b1) begin
         n_fail++; $display("FAIL midpress_up_before: enUP=%b required 1", enUP);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (enUP !== 1'b0 || en_count !== 4'd0) begin
         n_fail++; $display("FAIL midpress_reset: enUP=%b en_count=%0d, required 0/0", enUP, en_count);
      end
      #1 reset = 1'b1;
      tick(6);
      n_checks++;
      if (enUP !== 1'b0 || en_count !== 4'd1) begin
         n_fail++; $display("FAIL midpress_redebounce: enUP=%b en_count=%0d, required 0/1", enUP, en_count);
      end
      tick(1);
      n_checks++;
      if (enUP !== 1'b1) begin
         n_fail++; $display("FAIL midpress_up_after: enUP=%b required 1", enUP);
      end
      btn_up = 1'b0;
      config_mode = 1'b0;
      tick(10);
   endtask

   task automatic test_select_right;
      config_mode = 1'b1;
      tick(1);
      n_checks++;
      if (en_count !== 4'd1) begin
         n_fail++; $display("FAIL enter_select: en_count=%0d required 1", en_count);
      end
      press_lr(1'b1, 1'b0, 10);
      n_checks++;
      if (en_count !== 4'd2) begin
         n_fail++; $display("FAIL first_right: en_count=%0d required 2", en_count);
      end
      for (int i = 0; i < 6; i++) press_lr(1'b1, 1'b0, 10);
      n_checks++;
      if (en_count !== 4'd8) begin
         n_fail++; $display("FAIL seven_rights: en_count=%0d required 8", en_count);
      end
   endtask

   task automatic test_up_down;
      btn_up = 1'b1;
      tick(6);
      n_checks++;
      if (enUP !== 1'b0) begin
         n_fail++; $display("FAIL up_clk6: enUP=%b required 0", enUP);
      end
      tick(1);
      n_checks++;
      if (enUP !== 1'b1 || enDOWN !== 1'b0) begin
         n_fail++; $display("FAIL up_clk7: enUP=%b enDOWN=%b, required 1/0", enUP, enDOWN);
      end
      tick(13);
      btn_up = 1'b0;
      tick(6);
      n_checks++;
      if (enUP !== 1'b1) begin
         n_fail++; $display("FAIL up_release_clk6: enUP=%b required 1", enUP);
      end
      tick(1);
      n_checks++;
      if (enUP !== 1'b0 || enDOWN !== 1'b0) begin
         n_fail++; $display("FAIL up_release_clk7: enUP=%b enDOWN=%b, required 0/0", enUP, enDOWN);
      end
      tick(5);
      btn_down = 1'b1;
      tick(10);
      n_checks++;
      if (enDOWN !== 1'b1 || enUP !== 1'b0) begin
         n_fail++; $display("FAIL down_held: enDOWN=%b enUP=%b, required 1/0", enDOWN, enUP);
      end
      btn_down = 1'b0;
      tick(10);
      btn_up = 1'b1; btn_down = 1'b1;
      tick(15);
      n_checks++;
      if (enUP !== 1'b0 || enDOWN !== 1'b0) begin
         n_fail++; $display("FAIL up_down_both: enUP=%b enDOWN=%b, required 0/0", enUP, enDOWN);
      end
      btn_up = 1'b0; btn_down = 1'b0;
      tick(10);
      n_checks++;
      if (en_count !== 4'd8) begin
         n_fail++; $display("FAIL updown_field_kept: en_count=%0d required 8", en_count);
      end
   endtask

   task automatic test_glitch;
      press_lr(1'b1, 1'b0, 3);
      n_checks++;
      if (en_count !== 4'd8) begin
         n_fail++; $display("FAIL glitch_ignored: en_count=%0d required 8", en_count);
      end
      press_lr(1'b1, 1'b0, 4);
      tick(4);
      n_checks++;
      if (en_count !== 4'd9) begin
         n_fail++; $display("FAIL min_press_once: en_count=%0d required 9", en_count);
      end
   endtask

   task automatic test_boundary;
      press_lr(1'b1, 1'b0, 10);
      n_checks++;
      if (en_count !== EXP_RIGHT_AT_MAX) begin
         n_fail++; $display("FAIL right_at_max: en_count=%0d required %0d", en_count, EXP_RIGHT_AT_MAX);
      end
      config_mode = 1'b0;
      tick(1);
      config_mode = 1'b1;
      tick(1);
      n_checks++;
      if (en_count !== 4'd1) begin
         n_fail++; $display("FAIL reenter_select: en_count=%0d required 1", en_count);
      end
      press_lr(1'b0, 1'b1, 10);
      n_checks++;
      if (en_count !== EXP_LEFT_AT_MIN) begin
         n_fail++; $display("FAIL left_at_min: en_count=%0d required %0d", en_count, EXP_LEFT_AT_MIN);
      end
   endtask

   task automatic test_exit_and_both;
      btn_up = 1'b1;
      tick(10);
      n_checks++;
      if (enUP !== 1'b1) begin
         n_fail++; $display("FAIL up_before_exit: enUP=%b required 1", enUP);
      end
      config_mode = 1'b0;
      tick(1);
      n_checks++;
      if (en_count !== 4'd0 || enUP !== 1'b0) begin
         n_fail++; $display("FAIL exit_select: en_count=%0d enUP=%b, required 0/0", en_count, enUP);
      end
      btn_up = 1'b0;
      tick(10);
      config_mode = 1'b1;
      tick(1);
      press_lr(1'b1, 1'b0, 10);
      press_lr(1'b1, 1'b0, 10);
      n_checks++;
      if (en_count !== 4'd3) begin
         n_fail++; $display("FAIL two_rights: en_count=%0d required 3", en_count);
      end
      press_lr(1'b1, 1'b1, 10);
      n_checks++;
      if (en_count !== 4'd3) begin
         n_fail++; $display("FAIL left_right_same: en_count=%0d required 3", en_count);
      end
      press_lr(1'b0, 1'b1, 10);
      n_checks++;
      if (en_count !== 4'd2) begin
         n_fail++; $display("FAIL left_mid: en_count=%0d required 2", en_count);
      end
   endtask

   task automatic test_held_entry;
      config_mode = 1'b0;
      tick(2);
      btn_right = 1'b1; btn_up = 1'b1;
      tick(10);
      config_mode = 1'b1;
      tick(1);
      n_checks++;
      if (en_count !== 4'd1 || enUP !== 1'b0) begin
         n_fail++; $display("FAIL held_entry_first: en_count=%0d enUP=%b, required 1/0", en_count, enUP);
      end
      tick(1);
      n_checks++;
      if (enUP !== 1'b1) begin
         n_fail++; $display("FAIL held_entry_up: enUP=%b required 1", enUP);
      end
      tick(10);
      n_checks++;
      if (en_count !== 4'd1) begin
         n_fail++; $display("FAIL held_right_no_event: en_count=%0d required 1", en_count);
      end
      btn_right = 1'b0; btn_up = 1'b0;
      tick(10);
      press_lr(1'b1, 1'b0, 10);
      n_checks++;
      if (en_count !== 4'd2) begin
         n_fail++; $display("FAIL repress_right: en_count=%0d required 2", en_count);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_midpress_reset();
      test_select_right();
      test_up_down();
      test_glitch();
      test_boundary();
      test_exit_and_both();
      test_held_entry();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
